// File: rtl/seg_display_ctrl_pkg.sv
// rtl/seg_display_ctrl_pkg.sv - shared constants, FSM state type and BCD helper
//
// Purpose: segment patterns, datapath widths and the FSM state enum for the
// 3-digit 7-segment display controller.
package seg_pkg;

   localparam int BCD_W   = 12;
   localparam int BIN_W   = 10;
   localparam int BIN_MAX = 999;

   // Segment order {a,b,c,d,e,f,g}, active-high, a is the MSB.
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Double-dabble correction: a nibble of 5 or more would exceed 9 after the
   // next doubling, so pre-add 3 (4-bit wrap, no carry is possible from <=9).
   function automatic logic [3:0] dabble_adj(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// rtl/seg_display_ctrl_if.sv - value handshake between producer and display controller
//
// Purpose: groups the binary-value valid/ready handshake.
//   bin_valid  producer -> controller   value present on bin
//   bin_ready  controller -> producer   controller can accept
//   bin        producer -> controller   unsigned value 0..1023
interface seg_display_ctrl_if;
   import seg_pkg::*;

   logic             bin_valid;
   logic             bin_ready;
   logic [BIN_W-1:0] bin;

   modport master (output bin_valid, output bin, input bin_ready);
   modport slave  (input bin_valid, input bin, output bin_ready);

endinterface

// File: rtl/seg_display_ctrl_decode.sv
// rtl/seg_display_ctrl_decode.sv - combinational nibble to 7-segment pattern decoder
//
// Purpose: maps one BCD nibble to a segment pattern.
//   nibble   in   4  BCD digit; values above 9 render blank
//   blank    in   1  force blank (leading-zero suppression)
//   dash     in   1  force dash (overflow); wins over blank
//   pattern  out  7  {a,b,c,d,e,f,g}, active-high
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] pattern
);

   logic [6:0] digit_pat;

   always_comb begin
      digit_pat = SEG_BLANK;
      case (nibble)
         4'd0: digit_pat = SEG_DIGIT[0];
         4'd1: digit_pat = SEG_DIGIT[1];
         4'd2: digit_pat = SEG_DIGIT[2];
         4'd3: digit_pat = SEG_DIGIT[3];
         4'd4: digit_pat = SEG_DIGIT[4];
         4'd5: digit_pat = SEG_DIGIT[5];
         4'd6: digit_pat = SEG_DIGIT[6];
         4'd7: digit_pat = SEG_DIGIT[7];
         4'd8: digit_pat = SEG_DIGIT[8];
         4'd9: digit_pat = SEG_DIGIT[9];
         default: digit_pat = SEG_BLANK;
      endcase
   end

   always_comb begin
      pattern = digit_pat;
      if (dash)
         pattern = SEG_DASH;
      else if (blank)
         pattern = SEG_BLANK;
   end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - binary to BCD converter with multiplexed 3-digit 7-segment drive
//
// Purpose: accepts a 10-bit value, converts it to BCD one bit per clock
// (double-dabble), latches the result and scans it onto a shared segment bus.
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous, active-high reset
//   bin_if    slave    bin_valid / bin_ready / bin handshake
//   busy      out  1   conversion in progress
//   bcd       out  12  latched BCD {hundreds, tens, ones}
//   overflow  out  1   last accepted value was above 999
//   seg       out  7   segments {a..g}, active-high
//   dig_en    out  3   one-hot digit enable, bit0 = ones
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter bit LZ_BLANK = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   seg_display_ctrl_if.slave bin_if,
   output logic              busy,
   output logic [BCD_W-1:0]  bcd,
   output logic              overflow,
   output logic [6:0]        seg,
   output logic [2:0]        dig_en
);

   localparam int              SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   // ---------------- FSM ----------------
   state_t state, state_nxt;
   logic   accept;
   logic   last_bit;

   logic [BIN_W-1:0] shreg;
   logic [BCD_W-1:0] work;
   logic [BCD_W-1:0] work_adj;
   logic [3:0]       bit_cnt;
   logic             ovf_pending;

   assign last_bit = (bit_cnt == 4'd9);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      bin_if.bin_ready = 1'b0;
      busy             = 1'b0;
      accept           = 1'b0;
      case (state)
         IDLE: begin
            bin_if.bin_ready = 1'b1;
            accept           = bin_if.bin_valid;
            if (bin_if.bin_valid)
               state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- double-dabble datapath ----------------
   assign work_adj = {dabble_adj(work[11:8]), dabble_adj(work[7:4]), dabble_adj(work[3:0])};

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg       <= '0;
         work        <= '0;
         bit_cnt     <= '0;
         ovf_pending <= 1'b0;
         bcd         <= '0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg       <= bin_if.bin;
                  work        <= '0;
                  ovf_pending <= (bin_if.bin > BIN_W'(BIN_MAX));
                  bit_cnt     <= '0;
               end
            end
            SHIFT: begin
               {work, shreg} <= {work_adj[BCD_W-2:0], shreg, 1'b0};
               bit_cnt       <= bit_cnt + 4'd1;
               if (last_bit) begin
                  // The final shifted value is what {work, shreg} would hold
                  // after this edge; capture it directly into the output latch.
                  bcd      <= ovf_pending ? '0 : {work_adj[BCD_W-2:0], shreg[BIN_W-1]};
                  overflow <= ovf_pending;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- digit scan ----------------
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        dig_idx;
   logic [1:0]        idx_nxt;
   logic              scan_wrap;

   assign scan_wrap = (scan_cnt == SCAN_LAST);

   always_comb begin
      idx_nxt = dig_idx;
      if (scan_wrap)
         idx_nxt = (dig_idx == 2'd2) ? 2'd0 : (dig_idx + 2'd1);
   end

   // Decode the digit that will be enabled after this edge, so seg and dig_en
   // are registered together and always refer to the same digit.
   logic [3:0] sel_nibble;
   logic       sel_blank;
   logic [6:0] seg_nxt;

   always_comb begin
      sel_nibble = bcd[3:0];
      sel_blank  = 1'b0;
      case (idx_nxt)
         2'd2: begin
            sel_nibble = bcd[11:8];
            sel_blank  = LZ_BLANK && (bcd[11:8] == 4'd0);
         end
         2'd1: begin
            sel_nibble = bcd[7:4];
            sel_blank  = LZ_BLANK && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
         end
         default: begin
            sel_nibble = bcd[3:0];
            sel_blank  = 1'b0;
         end
      endcase
   end

   seg7_decode u_decode (
      .nibble  (sel_nibble),
      .blank   (sel_blank),
      .dash    (overflow),
      .pattern (seg_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         dig_idx  <= 2'd0;
         dig_en   <= 3'b001;
         seg      <= SEG_DIGIT[0];
      end else begin
         scan_cnt <= scan_wrap ? '0 : (scan_cnt + SCAN_W'(1));
         dig_idx  <= idx_nxt;
         dig_en   <= 3'b001 << idx_nxt;
         seg      <= seg_nxt;
      end
   end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Sequential controller for the board's 3-digit 7-segment display. It accepts a 10-bit binary value over a valid/ready handshake and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) sequence, one bit per clock. It latches the result and time-multiplexes the three digits onto a single shared segment bus with one-hot digit enables. It replaces per-digit combinational decoders and sits between the value producer and the display pins.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range ≥ 2.
- LZ_BLANK, 1: 1 = blank leading zeros; 0 = always show three digits.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bin_valid  in  1  producer has a value on bin.
- bin_ready  out  1  controller can accept a value.
- bin  in  10  unsigned binary value, 0..1023.
- busy  out  1  conversion in progress.
- bcd  out  12  latched BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- overflow  out  1  last accepted value was > 999.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-high; a is the MSB.
- dig_en  out  3  one-hot digit enable, active-high; bit0 = ones, bit2 = hundreds.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - bin_ready=1 and busy=0.
  - On bin_valid & bin_ready, capture bin into a shift register and clear the 12-bit working BCD.
  - Set ovf_pending = (bin > 999), clear the bit counter, go to SHIFT.
- SHIFT (exactly 10 cycles):
  - bin_ready=0 and busy=1.
  - Each cycle, any working nibble ≥ 5 first gets +3 (4-bit, no carry out), then {work, shreg} shifts left by 1.
  - The MSB of shreg enters work[0].
  - On the 10th cycle, load bcd from the final working value, or 12'h000 if ovf_pending.
  - On the same cycle, load overflow from ovf_pending, then return to IDLE.
- bin_valid while busy is ignored; the producer must hold its value until bin_ready.
- Scan:
  - A free-running counter runs 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→0.
  - Scan is independent of the FSM and never stalls.
- Segment encoding:
  - Digits: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Blank = 0000000. Dash = 0000001. Any nibble > 9 is shown as blank.
- Display selection priority:
  - overflow=1: all digits show dash.
  - Else, with LZ_BLANK=1: hundreds is blank if 0; tens is blank if hundreds and tens are both 0. Ones always shows.
- The display always shows the latched bcd/overflow; the working register is never visible, so there is no tearing mid-conversion.

## Timing
- Reset values:
  - State IDLE, bin_ready=1, busy=0, bcd=12'h000, overflow=0.
  - Scan counter 0, digit index 0, dig_en=3'b001, seg=1111110.
- Handshake latency:
  - Handshake at rising edge E0. SHIFT covers edges E1..E10.
  - bcd, overflow and bin_ready=1 are visible after E10. Total latency is 10 cycles.
  - The next handshake is earliest at E11 (throughput is one value per 11 cycles).
- seg and dig_en are both registered and change on the same edge, so there is no stale-segment glitch.
- Digit switching: each digit is enabled for exactly SCAN_DIV cycles; the full frame is 3·SCAN_DIV cycles.
- A bcd update landing mid-digit takes effect on seg one cycle after bcd changes. The digit index is not reset.
- Reset asserted mid-conversion aborts it: bcd/overflow return to reset values and the captured value is discarded.
- Handshake and scan wrap in the same cycle: both take effect, with no interaction.

## Structure
- Package seg_pkg holds:
  - the segment constants SEG_DIGIT[0:9], SEG_BLANK and SEG_DASH;
  - the FSM state enum (IDLE, SHIFT);
  - the BCD width constant (12) and the input width (10).
- Sub-module seg7_decode is combinational: inputs are a 4-bit nibble, blank and dash; output is the 7-bit pattern. It is instantiated once, on the selected digit, before the seg register.
- One file for seg_display_ctrl covers the FSM, the double-dabble datapath, the scan counter and the output registers.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset, then hold 12 cycles: dig_en walks 001 (cycles 0–3), 010 (4–7), 100 (8–11); seg=1111110 on ones; hundreds/tens blank with LZ_BLANK=1.
- bin=10'd987 handshake: bin_ready low for 10 cycles; then bcd=12'h987, overflow=0; digits show 1111011, 1111111, 1110000.
- bin=10'd5 with LZ_BLANK=1, then LZ_BLANK=0 in a second run: ones=1011011; hundreds/tens are 0000000 in the first run and 1111110 in the second.
- bin=10'd1023: bcd=12'h000, overflow=1, all three digits show 0000001. A following bin=10'd42 clears overflow, and the display shows 42 with the hundreds digit blanked (LZ_BLANK=1).
- bin_valid held high continuously with changing bin: only values sampled while bin_ready=1 are converted, one every 11 cycles, and each bcd matches its sampled value.
- Assert rst 4 cycles after a handshake for bin=10'd500: bcd stays 12'h000 and bin_ready=1 on the first cycle after reset.
